mux_arb: RTL
============

# mux_arb

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshaking for the BIP datapath. It replaces the fixed 16-bit 2:1 combinational selector wherever a source must be chosen among several producers and held for a consumer that may stall. Channel choice is either explicit (`sel` input) or round-robin among requesting channels. The selected word, and the index of the channel it came from, are registered on one output stage with back-pressure.

## Interface
- `WIDTH`, 16: data width per channel.
- `N_CH`, 4: number of input channels; minimum 2; need not be a power of two.
- `MODE`, 0: channel-choice mode. 0 = explicit select via `sel`. 1 = round-robin arbitration; `sel` is ignored.
- `SEL_W`, `$clog2(N_CH)`: width of `sel` and `out_ch`. Derived; do not override.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`  in  N_CH  channel i has a word available.
- `in_ready`  out  N_CH  one-hot or zero; channel i's word is accepted this cycle.
- `sel`  in  SEL_W  requested channel index; used only when MODE=0.
- `out_data`  out  WIDTH  registered selected word.
- `out_ch`  out  SEL_W  index of the channel that supplied `out_data`.
- `out_valid`  out  1  `out_data` and `out_ch` hold an unconsumed word.
- `out_ready`  in  1  consumer accepts the output word this cycle.
- `xfer_cnt`  out  16  count of accepted input words; wraps.

## Operation
- **Output register slot.**
  - `load = !out_valid || out_ready`: the slot is free now, or is being drained this cycle.
- **Grant, MODE=0.**
  - Grant channel `g = sel` when `sel < N_CH` and `in_valid[sel]` is 1.
  - Otherwise there is no grant.
  - Valid words on other channels are never taken.
- **Grant, MODE=1.**
  - Scan channels `ptr, ptr+1, …, N_CH-1, 0, …, ptr-1`.
  - Grant the first channel with `in_valid` set; if none is set, there is no grant.
- **Ready.**
  - `in_ready[g] = load && grant`.
  - All other bits are 0.
  - `in_ready` is combinational from `in_valid`, `sel`, `out_valid`, `out_ready` and `ptr`.
- **Transfer (load && grant).**
  - `out_data <= in_data[g]`, `out_ch <= g`, `out_valid <= 1`.
  - `xfer_cnt <= xfer_cnt + 1`, wrapping 0xFFFF -> 0.
  - `ptr <= (g == N_CH-1) ? 0 : g+1`.
- **Load with no grant:** `out_valid <= 0`. `out_data` and `out_ch` hold their values.
- **No load** (`out_valid && !out_ready`): all outputs and `ptr` hold; `in_ready` is all-zero.
- **`ptr`** is internal. It exists in MODE=1 only and stays constant 0 in MODE=0.
- **Reset.**
  - Forces `out_valid=0`, `out_data=0`, `out_ch=0`, `xfer_cnt=0`, `ptr=0`, regardless of handshake activity that cycle.
  - An in-flight output word is discarded.
  - Any input word presented in the reset cycle is not accepted: `in_ready` is all-zero while `reset=1`.

## Timing
- Latency is 1 cycle: a word accepted at edge k appears on `out_data` with `out_valid=1` after edge k.
- Throughput is one word per cycle when `out_ready` is held at 1.
- Simultaneous drain and fill: when `out_valid=1`, `out_ready=1` and a grant exists, the old word is consumed and the new word is loaded at the same edge. There is no bubble.
- Back-pressure: under stall, `out_data`, `out_ch` and `out_valid` stay stable until the cycle with `out_ready=1`.
- There is no combinational path from `in_data` to any output.

## Test plan
- **Reset values.** Hold `reset=1` for 2 cycles with all `in_valid=1` and `out_ready=1` -> during reset `in_ready=0000`. After release: `out_valid=0`, `out_data=0`, `out_ch=0`, `xfer_cnt=0`.
- **MODE=0 select.** Channels hold 0x1111, 0x2222, 0x3333, 0x4444, all valid; `sel=2`, `out_ready=1` -> `in_ready=0100`. One cycle later `out_data=0x3333`, `out_ch=2`, `xfer_cnt=1`. Then set `sel=1` with `in_valid[1]=0` -> `in_ready=0000`, and `out_valid` drops after the next edge.
- **MODE=1 fairness.** All 4 channels continuously valid, `out_ready=1` -> `out_ch` sequence is 0,1,2,3,0,1 on consecutive cycles. Then only channels 1 and 3 valid -> sequence 1,3,1,3.
- **Back-pressure.** Word 0xABCD is loaded, then `out_ready=0` for 3 cycles with a new valid input present -> `out_data` stays 0xABCD and `in_ready=0000`. On the cycle `out_ready=1`, the new word is loaded with no idle cycle.
- **Wrap and non-power-of-two.** Set `N_CH=3`, MODE=1, all channels valid -> `out_ch` sequence 0,1,2,0. Preload `xfer_cnt` to 0xFFFF via 65535 transfers; one more transfer -> `xfer_cnt=0`.
- **Reset mid-stream.** Assert `reset` while `out_valid=1` and a grant is pending -> after the reset edge `out_valid=0`, and the word is not counted. After release in MODE=1, arbitration restarts at channel 0.

Source files
------------

// File: rtl/mux_arb_if.sv
// Handshake bundle for mux_arb: N_CH producer lanes in, one registered word out.
// Latency: none; this is wiring only.
// Backpressure: carries in_ready per lane and out_ready from the consumer.
interface mux_arb_if #(
    parameter int WIDTH = 16,
    parameter int N_CH  = 4
);
    localparam int SEL_W = $clog2(N_CH);

    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic [SEL_W-1:0]      sel;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_ch;
    logic                  out_valid;
    logic                  out_ready;
    logic [15:0]           xfer_cnt;

    // Producer/consumer side: drives the lanes and the consumer ready.
    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_ch, out_valid, xfer_cnt
    );

    // Mux side.
    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_ch, out_valid, xfer_cnt
    );
endinterface

// File: rtl/mux_arb.sv
// N-channel registered mux, channel chosen by sel (MODE=0) or round-robin (MODE=1).
// Latency: 1 cycle from input acceptance to out_valid; one word per cycle sustained.
// Backpressure: output slot reloads when empty or draining; otherwise in_ready is all-zero.
module mux_arb #(
    parameter int WIDTH = 16,
    parameter int N_CH  = 4,
    parameter int MODE  = 0
) (
    input  logic     clk,
    input  logic     reset,
    mux_arb_if.slave bus
);
    localparam int SEL_W = $clog2(N_CH);

    logic [WIDTH-1:0] ch_dat [N_CH];
    logic [WIDTH-1:0] out_dat_q;
    logic [SEL_W-1:0] out_ch_q;
    logic             out_vld_q;
    logic [15:0]      cnt_q;
    logic [SEL_W-1:0] ptr;

    logic             load;
    logic             grant;
    logic [SEL_W-1:0] gnt_ch;
    logic [N_CH-1:0]  in_rdy;

    // Unpack the flat lane bus so the selected word is a plain array read.
    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        assign ch_dat[i] = bus.in_data[i*WIDTH +: WIDTH];
    end

    // The slot can take a word when it is empty or its word leaves this cycle.
    assign load = !out_vld_q || bus.out_ready;

    // Pick the granted channel: explicit select, or first requester from ptr onward.
    always_comb begin
        logic [SEL_W:0] c;
        grant  = 1'b0;
        gnt_ch = '0;
        c      = '0;
        if (MODE == 0) begin
            // sel may point past the last lane when N_CH is not a power of two.
            if (({1'b0, bus.sel} < (SEL_W+1)'(N_CH)) && bus.in_valid[bus.sel]) begin
                grant  = 1'b1;
                gnt_ch = bus.sel;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                // ptr + k wraps at most once because both are below N_CH.
                c = {1'b0, ptr} + (SEL_W+1)'(k);
                if (c >= (SEL_W+1)'(N_CH)) begin
                    c = c - (SEL_W+1)'(N_CH);
                end
                if (!grant && bus.in_valid[c[SEL_W-1:0]]) begin
                    grant  = 1'b1;
                    gnt_ch = c[SEL_W-1:0];
                end
            end
        end
    end

    // Accept strobe: only the granted lane, only when the slot can load, never in reset.
    always_comb begin
        in_rdy = '0;
        if (!reset && load && grant) begin
            in_rdy[gnt_ch] = 1'b1;
        end
    end

    // Output slot, transfer counter and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_dat_q <= '0;
            out_ch_q  <= '0;
            out_vld_q <= 1'b0;
            cnt_q     <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (grant) begin
                out_dat_q <= ch_dat[gnt_ch];
                out_ch_q  <= gnt_ch;
                out_vld_q <= 1'b1;
                cnt_q     <= cnt_q + 16'd1;
                // Next scan starts just after the winner, so every requester gets a turn.
                if (MODE == 1) begin
                    ptr <= (gnt_ch == SEL_W'(N_CH-1)) ? '0 : gnt_ch + SEL_W'(1);
                end
            end else begin
                out_vld_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_data  = out_dat_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_vld_q;
    assign bus.xfer_cnt  = cnt_q;
endmodule
